// File: rtl/stepper_pkg.sv
// Shared definitions for the framed serial-in/parallel-out receiver.
package stepper_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sipo_frame_rx_piso.sv
// Parallel-in/serial-out shift register, MSB first; used as a loopback transmitter.
module sipo_frame_rx_piso
    import stepper_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            load_in,
    input  logic [SIZE-1:0] par_in,
    input  logic            shift_en_in,
    output logic            ser_out,
    output logic            active_out
);

    localparam int CW = $clog2(SIZE + 1);

    logic [SIZE-1:0] word_q, word_d;
    logic [CW-1:0]   left_q, left_d;

    always_comb begin
        word_d = word_q;
        left_d = left_q;
        if (load_in) begin
            word_d = par_in;
            left_d = CW'(SIZE);
        end else if (shift_en_in && (left_q != '0)) begin
            word_d = {word_q[SIZE-2:0], 1'b0};
            left_d = left_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            word_q <= '0;
            left_q <= '0;
        end else begin
            word_q <= word_d;
            left_q <= left_d;
        end
    end

    assign ser_out    = word_q[SIZE-1];
    assign active_out = (left_q != '0);

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial-to-parallel receiver, MSB first, with valid/ready output
// handshake and a sticky overrun flag.
module sipo_frame_rx
    import stepper_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            en_in,
    input  logic            frame_in,
    input  logic            data_in,
    input  logic            ready_in,
    output logic [SIZE-1:0] data_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            overrun_out
);

    localparam int            CW   = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    // The top shift bit is never observed: the completing sample is appended
    // straight into data_out, so only SIZE-1 bits need storage.
    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-2:0]   shift_q, shift_d;
    logic [SIZE-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_in && frame_in) begin
                    shift_d    = '0;
                    shift_d[0] = data_in;
                    cnt_d      = CW'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (!frame_in) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (en_in) begin
                    if (cnt_q == LAST) begin
                        done    = 1'b1;
                        data_d  = {shift_q, data_in};
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = {shift_q[SIZE-3:0] , data_in} ;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing word always wins over acceptance of the previous one.
        if (done) begin
            valid_d = 1'b1;
            if (valid_q && !ready_in)
                overrun_d = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign busy_out    = (state_q == SHIFT);
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed plus randomized bench for sipo_frame_rx against a bit-queue reference model.
module tb_sipo_frame_rx;

    localparam int SIZE = 8;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            en_in = 1'b0;
    logic            frame_in = 1'b0;
    logic            data_in = 1'b0;
    logic            ready_in = 1'b0;
    logic [SIZE-1:0] data_out;
    logic            valid_out;
    logic            busy_out;
    logic            overrun_out;

    logic            tx_load = 1'b0;
    logic [SIZE-1:0] tx_par = '0;
    logic            tx_shift = 1'b0;
    logic            tx_ser;
    logic            tx_active;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [SIZE-1:0] last_valid_data = '0;

    // Reference model: bits of the word in progress, plus output registers.
    logic            m_bits[$];
    logic [SIZE-1:0] m_data = '0;
    logic            m_valid = 1'b0;
    logic            m_ovr = 1'b0;

    always #5 clk_in = ~clk_in;

    sipo_frame_rx #(.SIZE(SIZE)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en_in),
        .frame_in    (frame_in),
        .data_in     (data_in),
        .ready_in    (ready_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    sipo_frame_rx_piso #(.SIZE(SIZE)) tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (tx_load),
        .par_in      (tx_par),
        .shift_en_in (tx_shift),
        .ser_out     (tx_ser),
        .active_out  (tx_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input logic frame,
                              input logic din, input logic ready);
        logic            done;
        logic [SIZE-1:0] word;
        if (rst) begin
            m_bits.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        done = 1'b0;
        word = '0;
        if (!frame) begin
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(din);
            if (m_bits.size() == SIZE) begin
                for (int i = 0; i < SIZE; i++)
                    word = {word[SIZE-2:0], m_bits[i]};
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (m_valid && !ready)
                m_ovr = 1'b1;
            m_data  = word;
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick(input logic rst, input logic en, input logic frame,
                        input logic din, input logic ready);
        rst_in   = rst;
        en_in    = en;
        frame_in = frame;
        data_in  = din;
        ready_in = ready;
        @(posedge clk_in);
        model_step(rst, en, frame, din, ready);
        #1;
        if (valid_out === 1'b1) begin
            valid_cycles++;
            last_valid_data = data_out;
        end
        chk("model_data", 32'(data_out), 32'(m_data));
        chk("model_valid", 32'(valid_out), 32'(m_valid));
        chk("model_busy", 32'(busy_out), 32'(m_bits.size() != 0));
        chk("model_overrun", 32'(overrun_out), 32'(m_ovr));
    endtask

    // Sends one word MSB first inside an already-open frame; one bit every 'gap' cycles.
    task automatic send_word(input logic [SIZE-1:0] w, input int gap,
                             input logic ready_bits, input logic ready_last);
        for (int b = SIZE - 1; b >= 0; b--) begin
            for (int g = 1; g < gap; g++)
                tick(1'b0, 1'b0, 1'b1, 1'b0, ready_bits);
            tick(1'b0, 1'b1, 1'b1, w[b], (b == 0) ? ready_last : ready_bits);
        end
    endtask

    initial begin
        // Reset
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_busy", 32'(busy_out), 32'h0);
        chk("reset_overrun", 32'(overrun_out), 32'h0);

        // Continuous strobe, 0xA5
        send_word(8'hA5, 1, 1'b0, 1'b0);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_valid", 32'(valid_out), 32'h1);
        chk("a5_busy", 32'(busy_out), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_consumed", 32'(valid_out), 32'h0);

        // Strobe every third cycle, consumer always ready
        valid_cycles = 0;
        send_word(8'h3C, 3, 1'b1, 1'b1);
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_valid", 32'(valid_out), 32'h1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("3c_valid_cycles", 32'(valid_cycles), 32'd1);

        // Aborted partial word then a full 0x81
        valid_cycles = 0;
        for (int i = 0; i < 5; i++)
            tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_busy", 32'(busy_out), 32'h1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("abort_idle", 32'(busy_out), 32'h0);
        send_word(8'h81, 1, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("81_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("81_word", 32'(last_valid_data), 32'h81);

        // Two back-to-back words unconsumed -> overrun
        send_word(8'h12, 1, 1'b0, 1'b0);
        send_word(8'h34, 1, 1'b0, 1'b0);
        chk("ovr_data", 32'(data_out), 32'h34);
        chk("ovr_valid", 32'(valid_out), 32'h1);
        chk("ovr_flag", 32'(overrun_out), 32'h1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_sticky", 32'(overrun_out), 32'h1);
        chk("ovr_consumed", 32'(valid_out), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_reset", 32'(overrun_out), 32'h0);

        // Reset mid-word, then 0x5A received intact
        for (int i = 0; i < 4; i++)
            tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_data", 32'(data_out), 32'h0);
        chk("midrst_valid", 32'(valid_out), 32'h0);
        chk("midrst_busy", 32'(busy_out), 32'h0);
        chk("midrst_overrun", 32'(overrun_out), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 2, 1'b0, 1'b0);
        chk("5a_data", 32'(data_out), 32'h5A);
        chk("5a_valid", 32'(valid_out), 32'h1);

        // Completion on the same edge as acceptance
        send_word(8'h77, 1, 1'b0, 1'b1);
        chk("accept_data", 32'(data_out), 32'h77);
        chk("accept_valid", 32'(valid_out), 32'h1);
        chk("accept_overrun", 32'(overrun_out), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Loopback through the serial transmitter
        tx_par  = 8'hC3;
        tx_load = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_load  = 1'b0;
        tx_shift = 1'b1;
        for (int i = 0; i < SIZE; i++)
            tick(1'b0, 1'b1, 1'b1, tx_ser, 1'b0);
        tx_shift = 1'b0;
        chk("loop_data", 32'(data_out), 32'hC3);
        chk("loop_valid", 32'(valid_out), 32'h1);
        chk("loop_tx_done", 32'(tx_active), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 93),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 Parameter SIZE, default 8, word width in bits; SHALL be >= 2.
REQ-002 clk_in  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 en_in  input  1  bit strobe; data_in is sampled only on edges where en_in=1.
REQ-005 frame_in  input  1  frame select, active-high; low aborts any partial word.
REQ-006 data_in  input  1  serial data, MSB first.
REQ-007 ready_in  input  1  consumer accepts data_out on edges where valid_out=1 and ready_in=1.
REQ-008 data_out  output  SIZE  last completed word, registered.
REQ-009 valid_out  output  1  data_out holds an unconsumed word.
REQ-010 busy_out  output  1  a word is partially received (FSM in SHIFT).
REQ-011 overrun_out  output  1  sticky; a completed word overwrote an unconsumed word.

Function
REQ-012 FSM states SHALL be exactly IDLE and SHIFT; bit counter width $clog2(SIZE+1).
REQ-013 IDLE, en_in=1, frame_in=1: shift register <= {zeros, data_in}, count <= 1, next SHIFT.
REQ-014 IDLE otherwise: hold all state.
REQ-015 SHIFT, frame_in=0 (any en_in): discard shift register contents, count <= 0, next IDLE, valid_out unchanged.
REQ-016 SHIFT, frame_in=1, en_in=0: hold shift register and count.
REQ-017 SHIFT, frame_in=1, en_in=1, count < SIZE-1: shift register <= {shift[SIZE-2:0], data_in}, count++.
REQ-018 SHIFT, frame_in=1, en_in=1, count = SIZE-1: data_out <= {shift[SIZE-2:0], data_in}, valid_out <= 1, count <= 0, next IDLE.
REQ-019 Latency: data_out and valid_out are visible one edge after the SIZE-th qualified sample, i.e. in the cycle following that sampling edge.
REQ-020 Back-to-back words in one frame: after REQ-018, the next qualified bit re-enters via REQ-013 with no dead cycle beyond the strobe spacing.
REQ-021 Handshake: valid_out clears on an edge with valid_out=1, ready_in=1, and no word completing.
REQ-022 Completion on the same edge as acceptance: data_out takes the new word, valid_out stays 1, overrun_out unchanged.
REQ-023 Completion while valid_out=1 and ready_in=0: data_out overwritten, valid_out stays 1, overrun_out <= 1.
REQ-024 overrun_out SHALL clear only on reset.
REQ-025 busy_out = 1 exactly while the FSM is in SHIFT.
REQ-026 ready_in while valid_out=0 has no effect.

Reset
REQ-027 rst_in=1 on an edge SHALL override all other inputs: FSM IDLE, count 0, shift register 0, data_out 0, valid_out 0, busy_out 0, overrun_out 0.
REQ-028 Reset mid-word discards the partial word; the first frame after reset is received normally.

Structure
REQ-029 The FSM state encoding (IDLE, SHIFT) SHALL be defined in the shared package stepper_pkg; SIZE stays a module parameter.
REQ-030 One sub-module is natural: the existing parallel-in/serial-out shift register, used only as the bench loopback transmitter; the RTL itself is flat.

Verification (SIZE=8)
REQ-031 en_in=1 every cycle, frame_in=1 for 8 cycles, bits of 0xA5 -> data_out=0xA5, valid_out=1 the cycle after the 8th edge, busy_out=0.
REQ-032 en_in every 3rd cycle, 0x3C, ready_in=1 -> data_out=0x3C, valid_out high for exactly 1 cycle.
REQ-033 frame_in dropped after 5 bits, then a full frame of 0x81 -> exactly one valid word, 0x81.
REQ-034 Frame of 16 bits 0x12 then 0x34, ready_in=0 -> data_out=0x34, valid_out=1, overrun_out=1 until rst_in.
REQ-035 rst_in pulsed after bit 4 of 0xFF -> all outputs 0 next cycle; the following 0x5A frame is received intact.
REQ-036 Loopback: transmitter loaded with 0xC3, frame_in held high for the 8 shift-enable cycles after the load -> data_out=0xC3.
